// File: rtl/alu8_pkg.sv
// ---------------------------------------------------------------------------
// alu8_pkg
// Shared widths, opcode encodings and the 9-bit reference function of the
// registered 8-bit ALU. The function is used by the optional scoreboard in
// alu8_driver (macro ALU8_DRIVER_SCOREBOARD_EN) and by the testbench.
// ---------------------------------------------------------------------------
package alu8_pkg;

    localparam int DATA_W = 8;
    localparam int RES_W  = 9;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] OP_AND  = 3'd0;
    localparam logic [SEL_W-1:0] OP_NAND = 3'd1;
    localparam logic [SEL_W-1:0] OP_OR   = 3'd2;
    localparam logic [SEL_W-1:0] OP_NOR  = 3'd3;
    localparam logic [SEL_W-1:0] OP_XOR  = 3'd4;
    localparam logic [SEL_W-1:0] OP_XNOR = 3'd5;
    localparam logic [SEL_W-1:0] OP_ADD  = 3'd6;
    localparam logic [SEL_W-1:0] OP_SUB  = 3'd7;

    // The ALU works in a 9-bit context with zero-extended operands, so the
    // inverting ops set bit 8, ADD puts the carry there and SUB the borrow.
    function automatic logic [RES_W-1:0] alu8_model(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [SEL_W-1:0]  sel
    );
        logic [RES_W-1:0] ea;
        logic [RES_W-1:0] eb;
        logic [RES_W-1:0] r;
        ea = {1'b0, a};
        eb = {1'b0, b};
        case (sel)
            OP_AND:  r = ea & eb;
            OP_NAND: r = ~(ea & eb);
            OP_OR:   r = ea | eb;
            OP_NOR:  r = ~(ea | eb);
            OP_XOR:  r = ea ^ eb;
            OP_XNOR: r = ~(ea ^ eb);
            OP_ADD:  r = ea + eb;
            default: r = ea - eb;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu8_rsp_fifo.sv
// ---------------------------------------------------------------------------
// alu8_rsp_fifo
// Synchronous show-ahead FIFO holding tagged ALU results.
// Ports:
//   clk, rst (sync, active-low)
//   push, push_data[W-1:0]  write side
//   pop                     read side; head advances on pop
//   head[W-1:0]             current head entry (valid when count != 0)
//   count                   number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ---------------------------------------------------------------------------
module alu8_rsp_fifo #(
    parameter int W     = 13,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    // Head is read combinationally so the response appears on the same
    // cycle the entry lands; a registered read would add a bubble.
    logic [W-1:0]       mem [0:DEPTH-1];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged,
            // including when the buffer is full.
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/alu8_driver.sv
// ---------------------------------------------------------------------------
// alu8_driver
// Request-side front end for a registered 8-bit ALU. Accepted requests are
// registered onto the ALU inputs, their tags ride an (ALU_LAT+1)-stage shift
// register matching the ALU latency, and results are captured with their
// tags into a response FIFO. Credit flow control (FIFO occupancy plus ops in
// flight) keeps the FIFO from ever overflowing. The external ALU is expected
// to share rst so it is held in reset together with this block.
// Ports:
//   clk, rst (sync, active-low)
//   req_valid/req_ready, req_a, req_b, req_sel, req_tag   request side
//   alu_a, alu_b, alu_sel (registered), alu_result        ALU side
//   rsp_valid/rsp_ready, rsp_result, rsp_tag,
//   rsp_zero, rsp_carry                                   response side
//   busy                                                  work outstanding
//   err_sticky   only with ALU8_DRIVER_SCOREBOARD_EN defined: set when a
//                captured result differs from the built-in reference model
// ---------------------------------------------------------------------------
module alu8_driver
    import alu8_pkg::*;
#(
    parameter int ALU_LAT    = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [SEL_W-1:0]  req_sel,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [RES_W-1:0]  alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_result,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic              busy
`ifdef ALU8_DRIVER_SCOREBOARD_EN
    ,
    output logic              err_sticky
`endif
);

    localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + ALU_LAT + 2) + 1;
`ifdef ALU8_DRIVER_SCOREBOARD_EN
    localparam int FIFO_W = RES_W + TAG_W + RES_W;
`else
    localparam int FIFO_W = RES_W + TAG_W;
`endif

    logic                accept;
    logic                push;
    logic                pop;
    logic [FIFO_W-1:0]   push_data;
    logic [FIFO_W-1:0]   head;
    logic [FC_W-1:0]     fifo_count;
    logic [CNT_W-1:0]    inflight;

    logic [DATA_W-1:0]   alu_a_reg;
    logic [DATA_W-1:0]   alu_b_reg;
    logic [SEL_W-1:0]    alu_sel_reg;

    // Stage i valid means the op accepted i+1 edges ago is still on its way;
    // the last stage lines up with the ALU result register.
    logic [ALU_LAT:0]    stage_valid_reg;
    logic [TAG_W-1:0]    stage_tag_reg [0:ALU_LAT];

    assign accept = req_valid && req_ready;
    assign push   = stage_valid_reg[ALU_LAT];
    assign pop    = rsp_valid && rsp_ready;

    // ALU operand registers hold their last values when nothing is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_a_reg   <= '0;
            alu_b_reg   <= '0;
            alu_sel_reg <= '0;
        end else if (accept) begin
            alu_a_reg   <= req_a;
            alu_b_reg   <= req_b;
            alu_sel_reg <= req_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stage_valid_reg <= '0;
        end else begin
            stage_valid_reg <= {stage_valid_reg[ALU_LAT-1:0], accept};
        end
    end

    // Tags need no reset: they are only looked at alongside a valid bit.
    always_ff @(posedge clk) begin
        stage_tag_reg[0] <= req_tag;
        for (int i = 1; i <= ALU_LAT; i++) begin
            stage_tag_reg[i] <= stage_tag_reg[i-1];
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= ALU_LAT; i++) begin
            inflight = inflight + CNT_W'(stage_valid_reg[i]);
        end
    end

    // Every op in flight already owns a FIFO slot, so the sum can never
    // exceed the depth. Only registered state feeds this compare.
    assign req_ready = (CNT_W'(fifo_count) + inflight) < CNT_W'(FIFO_DEPTH);

`ifdef ALU8_DRIVER_SCOREBOARD_EN
    logic [RES_W-1:0]    stage_exp_reg [0:ALU_LAT];
    logic                err_sticky_reg;
    logic [RES_W-1:0]    head_exp;

    always_ff @(posedge clk) begin
        stage_exp_reg[0] <= alu8_model(req_a, req_b, req_sel);
        for (int i = 1; i <= ALU_LAT; i++) begin
            stage_exp_reg[i] <= stage_exp_reg[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_sticky_reg <= 1'b0;
        end else if (push && (alu_result != stage_exp_reg[ALU_LAT])) begin
            err_sticky_reg <= 1'b1;
        end
    end

    assign push_data  = {stage_exp_reg[ALU_LAT], alu_result, stage_tag_reg[ALU_LAT]};
    assign head_exp   = head[FIFO_W-1 -: RES_W];
    assign err_sticky = err_sticky_reg;
`else
    assign push_data  = {alu_result, stage_tag_reg[ALU_LAT]};
`endif

    alu8_rsp_fifo #(
        .W     (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_sel    = alu_sel_reg;
    assign rsp_valid  = (fifo_count != '0);
    assign rsp_result = head[TAG_W +: RES_W];
    assign rsp_tag    = head[TAG_W-1:0];
    assign rsp_zero   = (rsp_result[DATA_W-1:0] == '0);
    assign rsp_carry  = rsp_result[RES_W-1];
    assign busy       = (inflight != '0) || rsp_valid;

endmodule

// File: doc/alu8_driver.md
Name: alu8_driver

Overview:
- Request-side front end for the registered 8-bit ALU.
- Accepts tagged operation requests on a valid/ready interface and drives the ALU operand and select inputs.
- Tracks in-flight operations across the ALU's register latency and returns tagged 9-bit results with flags on a valid/ready response interface.
- Credit-based flow control guarantees the response buffer can never overflow under downstream backpressure.

Parameters:
- ALU_LAT, 1: register stages inside the driven ALU; legal values 1..4.
- FIFO_DEPTH, 4: response buffer entries; power of two, 2..16.
- TAG_W, 4: width of the request/response tag.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-low.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_a  in  8  operand A.
- req_b  in  8  operand B.
- req_sel  in  3  opcode: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 ADD, 7 SUB.
- req_tag  in  TAG_W  opaque tag, returned with the result.
- alu_a  out  8  to ALU operand A (registered).
- alu_b  out  8  to ALU operand B (registered).
- alu_sel  out  3  to ALU select (registered).
- alu_result  in  9  from ALU result register.
- rsp_valid  out  1  response available (FIFO not empty).
- rsp_ready  in  1  pop when rsp_valid && rsp_ready.
- rsp_result  out  9  FIFO head result.
- rsp_tag  out  TAG_W  FIFO head tag.
- rsp_zero  out  1  rsp_result[7:0]==0.
- rsp_carry  out  1  rsp_result[8].
- busy  out  1  any op in flight or buffered.

Behaviour:
- Reset (rst==0 at an edge):
  - alu_a, alu_b, alu_sel cleared to 0; in-flight pipeline cleared; FIFO emptied.
  - rsp_valid=0, busy=0; req_ready=1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight and buffered ops with no response emitted.
  - The ALU instance is held in reset whenever this block is in reset.
- Accept at edge E0:
  - alu_a/alu_b/alu_sel take the request values.
  - The tag and a valid bit enter stage 0 of an (ALU_LAT+1)-stage shift register.
  - With no accept, the ALU inputs hold their last values and stage 0 valid is 0.
- Capture: when stage[ALU_LAT] is valid, alu_result and its tag are pushed into the FIFO at that edge.
  - Minimum accept-to-rsp_valid latency is ALU_LAT+2 edges.
  - Throughput is 1 op/cycle.
- Ordering: strictly in-order; tags are not interpreted.
- Credits:
  - inflight = count of valid stages.
  - req_ready = (fifo_count + inflight) < FIFO_DEPTH, computed from registered state only (no combinational path from rsp_ready or req_valid).
  - A pop frees its credit in the cycle after the pop edge.
- FIFO:
  - A simultaneous push and pop in the same cycle is legal at any occupancy, including full, and leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow is impossible by the credit rule; underflow is impossible because pops are gated by rsp_valid.
- Result width rule: the ALU evaluates in 9-bit context with operands zero-extended.
  - NAND/NOR/XNOR therefore return bit8=1.
  - ADD bit8 = carry.
  - SUB bit8 = borrow (a<b); SUB wraps mod 512.
- busy = (inflight != 0) || rsp_valid.

Optional Feature:
- Macro ALU8_DRIVER_SCOREBOARD_EN.
- Defined:
  - A built-in reference model computes the expected 9-bit result at accept using the width rule above and carries it through the shift register and FIFO beside the tag.
  - At push, a mismatch against alu_result sets the extra output port err_sticky (1 bit).
  - err_sticky is cleared only by reset.
- Undefined: the model, its storage and the err_sticky port are absent.

Decomposition:
- Package alu8_pkg: DATA_W=8, RES_W=9, SEL_W=3, opcode localparams OP_AND..OP_SUB, and a function alu8_model(a,b,sel) used by the scoreboard and the bench.
- Sub-module alu8_rsp_fifo: parameterised synchronous FIFO (width RES_W+TAG_W [+RES_W]) with count output.

Test Plan:
- Hold rst=0 two cycles with req_valid=1 -> alu_a/alu_b/alu_sel=0, rsp_valid=0, busy=0; req_ready=1 after release.
- Single ADD a=0xFF b=0x01 tag=3, rsp_ready=1, ALU_LAT=1 -> rsp_valid 3 edges after accept; rsp_result=0x100, rsp_zero=1, rsp_carry=1, rsp_tag=3.
- 8 back-to-back ops, opcodes 0..7, a=0xF0 b=0xFF -> one response per cycle in order: 0x0F0, 0x10F, 0x0FF, 0x100, 0x00F, 0x1F0, 0x1EF, 0x1F1.
- rsp_ready=0 with continuous requests -> exactly 4 accepted, then req_ready=0; raise rsp_ready -> drain in order; req_ready=1 the cycle after the first pop.
- 3 ops in flight, assert reset one cycle -> no rsp_valid afterwards; req_ready=1; busy=0.
- SUB a=0x05 b=0x07 -> 0x1FE, carry=1, err_sticky=0; force alu_result bit0 wrong -> err_sticky=1 until reset (macro defined).
